prbs7_checker: RTL and testbench
================================

// Module: prbs7_checker
// PURPOSE
//   Downstream consumer of the degree-7 LFSR serial output (x^7 + x + 1, period 127).
//   Self-synchronises to the incoming bitstream and predicts each following bit.
//   Counts bit errors and flags loss of lock, so LFSR generator health is measurable in silicon.
//   Sits directly after the LFSR output register; Valid_SI is driven by the same write-enable that advances the LFSR.
// PARAMETERS
//   LOCK_CNT    16  consecutive correct predictions needed to declare lock (>=1)
//   WINDOW      64  valid bits per error-monitoring window while locked (>=2)
//   UNLOCK_ERR  8   errors inside one window that force loss of lock (1..WINDOW)
//   CNT_W       16  width of the error and bit counters
// PORTS
//   Clk_CI      in   1      clock; all state is updated on the rising edge
//   Rst_RBI     in   1      asynchronous active-low reset
//   Valid_SI    in   1      Bit_DI is valid this cycle; a cycle with Valid_SI=0 changes no state except Clear_SI effects
//   Bit_DI      in   1      serial PRBS bit from the LFSR
//   Clear_SI    in   1      synchronous clear of ErrCnt_DO and BitCnt_DO only
//   Locked_DO   out  1      checker is locked to the sequence
//   Err_DO      out  1      one-cycle pulse: the previous valid bit mismatched while locked
//   ErrCnt_DO   out  CNT_W  mismatches seen while locked, saturating
//   BitCnt_DO   out  CNT_W  valid bits compared while locked, saturating
// BEHAVIOUR
//   Reset: all outputs are 0, state=SEARCH, Hist=0, and all internal counters are 0.
//   Hist[6:0] holds the last 7 bits; Hist[0] is the newest. Prediction P = Hist[5] ^ Hist[6], i.e. b[n] = b[n-6] ^ b[n-7].
//   FSM states: FILL, SEARCH, LOCKED. Reset enters FILL.
//   FILL: each valid bit is shifted into Hist and increments FillCnt. After the 7th valid bit, go to SEARCH.
//   SEARCH: each valid bit is shifted into Hist.
//     - Match counts only if P == Bit_DI and Hist != 0; MatchCnt then increments.
//     - Otherwise MatchCnt is set to 0. An all-zero stream therefore never locks.
//     - When MatchCnt reaches LOCK_CNT, go to LOCKED. Locked_DO=1 in the cycle after that bit.
//     - On entry to LOCKED, the window counter and window error counter are zeroed.
//   LOCKED: flywheel mode. P is shifted into Hist instead of Bit_DI, so an isolated error does not corrupt later predictions.
//     - Every valid bit increments BitCnt_DO.
//     - A mismatch sets Err_DO=1 for exactly the next cycle, increments ErrCnt_DO, and increments WinErr.
//     - WinCnt counts valid bits. On the WINDOW-th bit, WinCnt and WinErr return to 0. An error on that same bit still counts toward the check below first.
//     - If WinErr reaches UNLOCK_ERR, go to FILL: Locked_DO=0 in the next cycle; Hist, FillCnt and MatchCnt are zeroed.
//     - ErrCnt_DO and BitCnt_DO hold their values across loss of lock.
//   Latency: Locked_DO, Err_DO and the counters reflect a bit in the cycle after it is sampled.
//   Saturation: ErrCnt_DO and BitCnt_DO stop at 2^CNT_W-1 and never wrap.
//   Clear_SI: has priority over a simultaneous increment. Both counters read 0 the next cycle and that bit is not counted.
//     - Err_DO still pulses for that bit.
//     - Clear_SI does not affect the FSM or Locked_DO.
//   Valid_SI=0: Err_DO returns to 0, and Hist, the FSM and all counters hold.
//   Asynchronous reset asserted mid-operation returns everything to the reset values immediately.
// TESTING
//   1. Reset, then idle with Valid_SI=0 for 20 cycles -> all outputs remain 0.
//   2. Clean LFSR stream, seed 7'h01, Valid every cycle -> Locked_DO rises the cycle after valid bit 23.
//      After 127 further bits: BitCnt_DO=127, ErrCnt_DO=0, Err_DO never asserted.
//   3. While locked, invert one bit -> single Err_DO pulse, ErrCnt_DO=1, Locked_DO stays 1, no further errors.
//   4. While locked, invert 8 bits within 64 -> Locked_DO falls after the 8th, ErrCnt_DO=8.
//      Clean stream afterwards -> relock 23 valid bits later, counters held.
//   5. All-zero stream for 300 bits -> Locked_DO never asserts. Random gaps in Valid_SI on a clean stream -> same lock point as test 2, counted in valid bits.
//   6. Clear_SI coincident with an injected error -> ErrCnt_DO=0 and Err_DO=1.
//      Rst_RBI pulsed low mid-lock -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/prbs7_checker.sv
// PRBS7 (x^7 + x + 1) stream checker: self-synchronising bit predictor with
// flywheel lock, windowed loss-of-lock detection and saturating error/bit counters.
module prbs7_checker #(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned UNLOCK_ERR = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Valid_SI,
  input  logic             Bit_DI,
  input  logic             Clear_SI,
  output logic             Locked_DO,
  output logic             Err_DO,
  output logic [CNT_W-1:0] ErrCnt_DO,
  output logic [CNT_W-1:0] BitCnt_DO
);

  localparam int unsigned MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int unsigned WIN_W   = $clog2(WINDOW);
  localparam int unsigned WERR_W  = $clog2(UNLOCK_ERR + 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SEARCH,
    ST_LOCKED
  } state_e;

  state_e              state_q;
  logic [6:0]          hist_q;
  logic [2:0]          fill_cnt_q;
  logic [MATCH_W-1:0]  match_cnt_q;
  logic [WIN_W-1:0]    win_cnt_q;
  logic [WERR_W-1:0]   win_err_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic                locked_q;
  logic                err_q;

  logic                pred_c;
  logic                mismatch_c;
  logic                match_c;
  logic                win_end_c;
  logic                unlock_c;
  logic [6:0]          hist_d;
  logic [WERR_W-1:0]   win_err_d;
  logic [CNT_W-1:0]    err_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_d;

  // Prediction, comparison and saturating next values for the counters
  always_comb begin
    pred_c     = hist_q[5] ^ hist_q[6];
    mismatch_c = pred_c ^ Bit_DI;
    match_c    = !mismatch_c && (hist_q != 7'd0);
    win_end_c  = (win_cnt_q == WIN_W'(WINDOW - 1));
    win_err_d  = win_err_q + WERR_W'(mismatch_c);
    unlock_c   = (win_err_d == WERR_W'(UNLOCK_ERR));
    // Flywheel: once locked the history follows the prediction, not the input
    hist_d     = (state_q == ST_LOCKED) ? {hist_q[5:0], pred_c} : {hist_q[5:0], Bit_DI};
    err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
    bit_cnt_d  = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
  end

  // Checker FSM with registered outputs; only valid bits advance state
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q     <= ST_FILL;
      hist_q      <= 7'd0;
      fill_cnt_q  <= 3'd0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (Valid_SI) begin
        case (state_q)
          ST_FILL: begin
            hist_q <= hist_d;
            if (fill_cnt_q == 3'd6) begin
              fill_cnt_q <= 3'd0;
              state_q    <= ST_SEARCH;
            end else begin
              fill_cnt_q <= fill_cnt_q + 3'd1;
            end
          end
          ST_SEARCH: begin
            hist_q <= hist_d;
            if (!match_c) begin
              match_cnt_q <= '0;
            end else if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              match_cnt_q <= '0;
              win_cnt_q   <= '0;
              win_err_q   <= '0;
              locked_q    <= 1'b1;
              state_q     <= ST_LOCKED;
            end else begin
              match_cnt_q <= match_cnt_q + MATCH_W'(1);
            end
          end
          ST_LOCKED: begin
            hist_q    <= hist_d;
            bit_cnt_q <= bit_cnt_d;
            if (mismatch_c) begin
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_d;
            end
            if (unlock_c) begin
              state_q     <= ST_FILL;
              locked_q    <= 1'b0;
              hist_q      <= 7'd0;
              fill_cnt_q  <= 3'd0;
              match_cnt_q <= '0;
              win_cnt_q   <= '0;
              win_err_q   <= '0;
            end else if (win_end_c) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + WIN_W'(1);
              win_err_q <= win_err_d;
            end
          end
          default: state_q <= ST_FILL;
        endcase
      end
      // Clear wins over any increment made above in the same cycle
      if (Clear_SI) begin
        err_cnt_q <= '0;
        bit_cnt_q <= '0;
      end
    end
  end

  assign Locked_DO = locked_q;
  assign Err_DO    = err_q;
  assign ErrCnt_DO = err_cnt_q;
  assign BitCnt_DO = bit_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Testbench for prbs7_checker: randomized stimulus against a queue-based reference model.
module tb_prbs7_checker;

  localparam int LOCK_CNT   = 16;
  localparam int WINDOW     = 64;
  localparam int UNLOCK_ERR = 8;
  localparam int CNT_W      = 16;

  logic             Clk_CI = 1'b0;
  logic             Rst_RBI;
  logic             Valid_SI;
  logic             Bit_DI;
  logic             Clear_SI;
  logic             Locked_DO;
  logic             Err_DO;
  logic [CNT_W-1:0] ErrCnt_DO;
  logic [CNT_W-1:0] BitCnt_DO;

  int n_tests = 0;
  int n_fail  = 0;

  prbs7_checker #(
    .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(CNT_W)
  ) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Valid_SI(Valid_SI), .Bit_DI(Bit_DI),
    .Clear_SI(Clear_SI), .Locked_DO(Locked_DO), .Err_DO(Err_DO),
    .ErrCnt_DO(ErrCnt_DO), .BitCnt_DO(BitCnt_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  // PRBS7 reference sequence b[n] = b[n-6] ^ b[n-7], seeded from 7'h01
  bit seq [0:126];
  int sidx = 0;

  function automatic bit next_bit();
    bit b;
    b = seq[sidx % 127];
    sidx++;
    return b;
  endfunction

  // Reference model: history kept as a queue of real bits (oldest first)
  int               m_mode;          // 0 fill, 1 search, 2 locked
  bit               m_h[$];
  int               m_match, m_win, m_winerr;
  logic             m_locked, m_err;
  logic [CNT_W-1:0] m_errcnt, m_bitcnt;

  task automatic model_reset();
    m_mode = 0; m_h.delete(); m_match = 0; m_win = 0; m_winerr = 0;
    m_locked = 0; m_err = 0; m_errcnt = '0; m_bitcnt = '0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    bit p, nz, mis;
    m_err = 0;
    if (v) begin
      p = (m_h.size() == 7) ? (m_h[0] ^ m_h[1]) : 1'b0;
      if (m_mode == 0) begin
        m_h.push_back(b);
        if (m_h.size() == 7) m_mode = 1;
      end else if (m_mode == 1) begin
        nz = 0;
        foreach (m_h[i]) nz |= m_h[i];
        m_h.push_back(b); void'(m_h.pop_front());
        if (p == b && nz) m_match++; else m_match = 0;
        if (m_match == LOCK_CNT) begin
          m_mode = 2; m_locked = 1; m_match = 0; m_win = 0; m_winerr = 0;
        end
      end else begin
        mis = (p != b);
        m_h.push_back(p); void'(m_h.pop_front());
        if (m_bitcnt != '1) m_bitcnt++;
        if (mis) begin
          m_err = 1;
          if (m_errcnt != '1) m_errcnt++;
          m_winerr++;
        end
        m_win++;
        if (m_winerr >= UNLOCK_ERR) begin
          m_mode = 0; m_locked = 0; m_h.delete(); m_match = 0;
        end else if (m_win == WINDOW) begin
          m_win = 0; m_winerr = 0;
        end
      end
    end
    if (c) begin m_errcnt = '0; m_bitcnt = '0; end
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    @(negedge Clk_CI);
    Valid_SI = v; Bit_DI = b; Clear_SI = c;
    @(posedge Clk_CI);
    #1;
    model_step(v, b, c);
  endtask

  task automatic do_reset();
    @(negedge Clk_CI);
    Rst_RBI = 0; Valid_SI = 0; Bit_DI = 0; Clear_SI = 0;
    model_reset();
    repeat (2) @(negedge Clk_CI);
    Rst_RBI = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'($urandom), 1'b0);
      n_tests++;
      if ({Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got lk=%b er=%b ec=%0d bc=%0d want all 0",
                 i, Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO);
      end
    end
  endtask

  task automatic test_clean_lock();
    int errs = 0;
    do_reset();
    for (int i = 1; i <= 23 + 127; i++) begin
      step(1'b1, next_bit(), 1'b0);
      errs += int'(Err_DO);
      n_tests++;
      if ({Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO} !== {m_locked, m_err, m_errcnt, m_bitcnt}) begin
        n_fail++;
        $display("FAIL clean_model bit=%0d got lk=%b er=%b ec=%0d bc=%0d want lk=%b er=%b ec=%0d bc=%0d",
                 i, Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO, m_locked, m_err, m_errcnt, m_bitcnt);
      end
      if (i == 22 || i == 23) begin
        n_tests++;
        if (Locked_DO !== (i == 23)) begin
          n_fail++;
          $display("FAIL lock_point bit=%0d got %b want %b", i, Locked_DO, (i == 23));
        end
      end
    end
    n_tests++;
    if (BitCnt_DO !== 16'd127 || ErrCnt_DO !== 16'd0 || errs != 0) begin
      n_fail++;
      $display("FAIL clean_counts got bc=%0d ec=%0d pulses=%0d want 127 0 0", BitCnt_DO, ErrCnt_DO, errs);
    end
  endtask

  task automatic test_single_error();
    int errs = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, next_bit() ^ (i == 10), 1'b0);
      errs += int'(Err_DO);
      n_tests++;
      if ({Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO} !== {m_locked, m_err, m_errcnt, m_bitcnt}) begin
        n_fail++;
        $display("FAIL single_model i=%0d got lk=%b er=%b ec=%0d want lk=%b er=%b ec=%0d",
                 i, Locked_DO, Err_DO, ErrCnt_DO, m_locked, m_err, m_errcnt);
      end
    end
    n_tests++;
    if (errs != 1 || ErrCnt_DO !== 16'd1 || Locked_DO !== 1'b1) begin
      n_fail++;
      $display("FAIL single_err got pulses=%0d ec=%0d lk=%b want 1 1 1", errs, ErrCnt_DO, Locked_DO);
    end
  endtask

  task automatic test_unlock_relock();
    do_reset();
    for (int i = 0; i < 23; i++) step(1'b1, next_bit(), 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, ~next_bit(), 1'b0);
      n_tests++;
      if ({Locked_DO, Err_DO, ErrCnt_DO} !== {m_locked, m_err, m_errcnt} || Locked_DO !== (i < 8)) begin
        n_fail++;
        $display("FAIL unlock err=%0d got lk=%b er=%b ec=%0d want lk=%b er=%b ec=%0d",
                 i, Locked_DO, Err_DO, ErrCnt_DO, (i < 8), m_err, m_errcnt);
      end
    end
    for (int i = 1; i <= 23; i++) begin
      step(1'b1, next_bit(), 1'b0);
      n_tests++;
      if (Locked_DO !== (i == 23) || ErrCnt_DO !== 16'd8 || BitCnt_DO !== 16'd8) begin
        n_fail++;
        $display("FAIL relock bit=%0d got lk=%b ec=%0d bc=%0d want lk=%b ec=8 bc=8",
                 i, Locked_DO, ErrCnt_DO, BitCnt_DO, (i == 23));
      end
    end
  endtask

  task automatic test_zero_stream();
    int locks = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0);
      locks += int'(Locked_DO);
    end
    n_tests++;
    if (locks != 0) begin
      n_fail++;
      $display("FAIL zero_stream got locked_cycles=%0d want 0", locks);
    end
  endtask

  task automatic test_gaps();
    int nvalid = 0;
    int cyc = 0;
    bit v;
    do_reset();
    while (nvalid < 23 && cyc < 400) begin
      v = ($urandom_range(0, 1) == 1);
      step(v, v ? next_bit() : 1'($urandom), 1'b0);
      if (v) nvalid++;
      cyc++;
      n_tests++;
      if (Locked_DO !== (nvalid == 23)) begin
        n_fail++;
        $display("FAIL gap_lock valid=%0d got %b want %b", nvalid, Locked_DO, (nvalid == 23));
      end
    end
    n_tests++;
    if (nvalid != 23) begin
      n_fail++;
      $display("FAIL gap_budget got valid=%0d want 23", nvalid);
    end
    // Random gaps, sparse errors and clears checked against the model
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, v ? (next_bit() ^ ($urandom_range(0, 24) == 0)) : 1'($urandom),
           ($urandom_range(0, 31) == 0));
      n_tests++;
      if ({Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO} !== {m_locked, m_err, m_errcnt, m_bitcnt}) begin
        n_fail++;
        $display("FAIL random_model i=%0d got lk=%b er=%b ec=%0d bc=%0d want lk=%b er=%b ec=%0d bc=%0d",
                 i, Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO, m_locked, m_err, m_errcnt, m_bitcnt);
      end
    end
  endtask

  task automatic test_clear_err();
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, next_bit(), 1'b0);
    step(1'b1, ~next_bit(), 1'b1);
    n_tests++;
    if (ErrCnt_DO !== 16'd0 || BitCnt_DO !== 16'd0 || Err_DO !== 1'b1 || Locked_DO !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_err got ec=%0d bc=%0d er=%b lk=%b want 0 0 1 1",
               ErrCnt_DO, BitCnt_DO, Err_DO, Locked_DO);
    end
    step(1'b1, next_bit(), 1'b0);
    n_tests++;
    if (Err_DO !== 1'b0 || BitCnt_DO !== 16'd1 || ErrCnt_DO !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_after got er=%b bc=%0d ec=%0d want 0 1 0", Err_DO, BitCnt_DO, ErrCnt_DO);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, next_bit() ^ (i == 2), 1'b0);
    n_tests++;
    if (Locked_DO !== 1'b1 || BitCnt_DO === 16'd0) begin
      n_fail++;
      $display("FAIL pre_reset got lk=%b bc=%0d want lk=1 bc>0", Locked_DO, BitCnt_DO);
    end
    @(negedge Clk_CI);
    #2 Rst_RBI = 0;
    #1;
    n_tests++;
    if ({Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got lk=%b er=%b ec=%0d bc=%0d want all 0",
               Locked_DO, Err_DO, ErrCnt_DO, BitCnt_DO);
    end
    model_reset();
    @(negedge Clk_CI);
    Rst_RBI = 1;
  endtask

  initial begin
    logic [6:0] seed;
    seed = 7'h01;
    for (int i = 0; i < 7; i++) seq[i] = seed[6 - i];
    for (int i = 7; i < 127; i++) seq[i] = seq[i - 6] ^ seq[i - 7];
    Rst_RBI = 0; Valid_SI = 0; Bit_DI = 0; Clear_SI = 0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_unlock_relock();
    test_zero_stream();
    test_gaps();
    test_clear_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
